// File: rtl/aes_stream_arbiter_pkg.sv
// Shared types and helpers for the AES stream arbiter slice.
package aes_stream_arbiter_pkg;

    // Request-side arbiter states
    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_FORWARD = 1'b1
    } arb_state_e;

    // Ceiling log2, as used throughout the codebase for pointer/index widths
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/aes_stream_arbiter_id_fifo.sv
// In-order FIFO of granted requester IDs; the head tells the response path
// which requester the controller is currently answering.
module aes_arb_id_fifo
    import aes_stream_arbiter_pkg::*;
#(
    parameter int unsigned ID_W  = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic            full,
    output logic            empty,
    output logic [ID_W-1:0] head
);

    localparam int unsigned AW = clogb2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [ID_W-1:0] mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // Pointer update; extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage write, no reset needed on the payload
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_id;
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/aes_stream_arbiter.sv
// Packet-level round-robin arbiter sharing one AES controller among
// NUM_REQ requester streams; responses are steered back in grant order.
module aes_stream_arbiter
    import aes_stream_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned ORDER_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_tvalid,
    output logic [NUM_REQ-1:0]            req_tready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata,
    input  logic [NUM_REQ-1:0]            req_tlast,
    output logic                          dn_tvalid,
    input  logic                          dn_tready,
    output logic [DATA_WIDTH-1:0]         dn_tdata,
    output logic                          dn_tlast,
    input  logic                          rsp_tvalid,
    output logic                          rsp_tready,
    input  logic [DATA_WIDTH-1:0]         rsp_tdata,
    input  logic                          rsp_tlast,
    output logic [NUM_REQ-1:0]            out_tvalid,
    input  logic [NUM_REQ-1:0]            out_tready,
    output logic [DATA_WIDTH-1:0]         out_tdata,
    output logic                          out_tlast,
    output logic                          busy
);

    localparam int unsigned ID_W = (clogb2(NUM_REQ) > 1) ? clogb2(NUM_REQ) : 1;

    arb_state_e      state;
    arb_state_e      state_next;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] grant_id_next;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_ptr_next;
    logic [ID_W-1:0] sel_id;
    logic            sel_found;
    logic [ID_W:0]   rot_sum;
    logic [ID_W-1:0] rot_cand;
    logic [ID_W-1:0] head_id;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;

    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_data_arr[g] = req_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        rot_sum   = '0;
        rot_cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            rot_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (rot_sum >= (ID_W+1)'(NUM_REQ)) begin
                rot_sum = rot_sum - (ID_W+1)'(NUM_REQ);
            end
            rot_cand = rot_sum[ID_W-1:0];
            if (!sel_found && req_tvalid[rot_cand]) begin
                sel_found = 1'b1;
                sel_id    = rot_cand;
            end
        end
    end

    // Request FSM: grant in IDLE, pass the granted stream through in FORWARD
    always_comb begin
        state_next    = state;
        grant_id_next = grant_id;
        rr_ptr_next   = rr_ptr;
        fifo_push     = 1'b0;
        dn_tvalid     = 1'b0;
        req_tready    = '0;
        case (state)
            ARB_IDLE: begin
                if (!fifo_full && sel_found) begin
                    grant_id_next = sel_id;
                    fifo_push     = 1'b1;
                    state_next    = ARB_FORWARD;
                end
            end
            ARB_FORWARD: begin
                dn_tvalid            = req_tvalid[grant_id];
                req_tready[grant_id] = dn_tready;
                if (dn_tvalid && dn_tready && dn_tlast) begin
                    rr_ptr_next = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                    state_next  = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Arbiter state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ARB_IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_next;
            grant_id <= grant_id_next;
            rr_ptr   <= rr_ptr_next;
        end
    end

    assign dn_tdata = req_data_arr[grant_id];
    assign dn_tlast = req_tlast[grant_id];

    // Response steering to the requester at the head of the order FIFO
    always_comb begin
        out_tvalid = '0;
        rsp_tready = 1'b0;
        fifo_pop   = 1'b0;
        if (!fifo_empty) begin
            out_tvalid[head_id] = rsp_tvalid;
            rsp_tready          = out_tready[head_id];
            fifo_pop            = rsp_tvalid && out_tready[head_id] && rsp_tlast;
        end
    end

    assign out_tdata = rsp_tdata;
    assign out_tlast = rsp_tlast;
    assign busy      = (state == ARB_FORWARD) || !fifo_empty;

    aes_arb_id_fifo #(
        .ID_W  (ID_W),
        .DEPTH (ORDER_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .push_id (sel_id),
        .pop     (fifo_pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head_id)
    );

endmodule

// File: tb/tb_aes_stream_arbiter.sv
// Scoreboard bench for aes_stream_arbiter: random requester/controller traffic,
// packet-level reference model predicting grant order and response routing.
module tb_aes_stream_arbiter;

    localparam int N     = 3;
    localparam int DW    = 64;
    localparam int DEPTH = 2;
    localparam int MAXB  = 512;
    localparam int PKTS  = 60;

    typedef struct packed {
        logic [7:0]    id;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_tvalid = '0;
    logic [N-1:0]    req_tready;
    logic [N*DW-1:0] req_tdata = '0;
    logic [N-1:0]    req_tlast = '0;
    logic            dn_tvalid;
    logic            dn_tready = 1'b0;
    logic [DW-1:0]   dn_tdata;
    logic            dn_tlast;
    logic            rsp_tvalid = 1'b0;
    logic            rsp_tready;
    logic [DW-1:0]   rsp_tdata = '0;
    logic            rsp_tlast = 1'b0;
    logic [N-1:0]    out_tvalid;
    logic [N-1:0]    out_tready = '0;
    logic [DW-1:0]   out_tdata;
    logic            out_tlast;
    logic            busy;

    aes_stream_arbiter #(
        .NUM_REQ     (N),
        .DATA_WIDTH  (DW),
        .ORDER_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_tvalid (req_tvalid),
        .req_tready (req_tready),
        .req_tdata  (req_tdata),
        .req_tlast  (req_tlast),
        .dn_tvalid  (dn_tvalid),
        .dn_tready  (dn_tready),
        .dn_tdata   (dn_tdata),
        .dn_tlast   (dn_tlast),
        .rsp_tvalid (rsp_tvalid),
        .rsp_tready (rsp_tready),
        .rsp_tdata  (rsp_tdata),
        .rsp_tlast  (rsp_tlast),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready),
        .out_tdata  (out_tdata),
        .out_tlast  (out_tlast),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Requester packet images
    logic [DW-1:0] beat_data [N][MAXB];
    logic          beat_last [N][MAXB];
    int            nbeats [N];
    int            rpos [N];
    int            m_pos [N];

    // Scoreboard queues
    beat_t exp_dn[$];
    beat_t exp_out[$];
    beat_t ctrl_q[$];

    // Reference model state
    bit m_fwd = 1'b0;
    int m_cur = 0;
    int m_rr  = 0;
    int m_ids[$];

    bit hs_req [N];
    bit hs_rsp = 1'b0;
    int rst_cycles = 3;
    int p_valid = 100, p_dnr = 100, p_rsp = 100, p_outr = 100;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver: applies last cycle's handshakes, then drives new inputs
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (hs_req[i]) rpos[i]++;
            hs_req[i] = 1'b0;
        end
        if (hs_rsp) begin
            if (ctrl_q.size() > 0) void'(ctrl_q.pop_front());
            hs_rsp = 1'b0;
        end
        if (rst_cycles > 0) begin
            reset = 1'b1;
            rst_cycles--;
        end else begin
            reset = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            req_tvalid[i] = !reset && (rpos[i] < nbeats[i]) && ($urandom_range(99) < p_valid);
            req_tdata[i*DW +: DW] = (rpos[i] < nbeats[i]) ? beat_data[i][rpos[i]] : '0;
            req_tlast[i] = (rpos[i] < nbeats[i]) ? beat_last[i][rpos[i]] : 1'b0;
            out_tready[i] = ($urandom_range(99) < p_outr);
        end
        dn_tready = ($urandom_range(99) < p_dnr);
        if (ctrl_q.size() > 0) begin
            rsp_tvalid = !reset && ($urandom_range(99) < p_rsp);
            rsp_tdata  = ctrl_q[0].data;
            rsp_tlast  = ctrl_q[0].last;
        end else begin
            rsp_tvalid = 1'b0;
            rsp_tdata  = '0;
            rsp_tlast  = 1'b0;
        end
    end

    // Monitor: compares outputs against the model and pops the scoreboards
    always @(negedge clk) begin
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_ov;
        beat_t e;
        beat_t r;
        int nb;
        #2;
        exp_rdy = '0;
        exp_ov  = '0;
        if (m_fwd) exp_rdy[m_cur] = dn_tready;
        if (m_ids.size() > 0) exp_ov[m_ids[0]] = rsp_tvalid;
        check("req_tready", req_tready, exp_rdy);
        check("dn_tvalid", dn_tvalid, m_fwd && req_tvalid[m_cur]);
        check("rsp_tready", rsp_tready, (m_ids.size() > 0) && out_tready[m_ids[0]]);
        check("out_tvalid", out_tvalid, exp_ov);
        check("busy", busy, m_fwd || (m_ids.size() > 0));

        for (int i = 0; i < N; i++) hs_req[i] = req_tvalid[i] && req_tready[i];
        hs_rsp = rsp_tvalid && rsp_tready;

        if (dn_tvalid && dn_tready) begin
            if (exp_dn.size() == 0) begin
                check("dn_unexpected_beat", 1'b1, 1'b0);
            end else begin
                e = exp_dn.pop_front();
                check("dn_tdata", dn_tdata, e.data);
                check("dn_tlast", dn_tlast, e.last);
                if (e.last) begin
                    nb = $urandom_range(1, 3);
                    for (int b = 0; b < nb; b++) begin
                        r.id   = e.id;
                        r.data = {$urandom, $urandom};
                        r.last = (b == nb - 1);
                        ctrl_q.push_back(r);
                        exp_out.push_back(r);
                    end
                end
            end
        end

        for (int i = 0; i < N; i++) begin
            if (out_tvalid[i] && out_tready[i]) begin
                if (exp_out.size() == 0) begin
                    check("out_unexpected_beat", 1'b1, 1'b0);
                end else begin
                    e = exp_out.pop_front();
                    check("out_route", 8'(i), e.id);
                    check("out_tdata", out_tdata, e.data);
                    check("out_tlast", out_tlast, e.last);
                end
            end
        end
    end

    // Reference model: packet-level grant order and outstanding-ID list
    always @(negedge clk) begin
        bit fwd0;
        bit full0;
        bit picked;
        int j;
        beat_t e;
        #3;
        if (reset) begin
            m_fwd = 1'b0;
            m_cur = 0;
            m_rr  = 0;
            m_ids.delete();
            exp_dn.delete();
            exp_out.delete();
            ctrl_q.delete();
            hs_rsp = 1'b0;
            for (int i = 0; i < N; i++) begin
                rpos[i]   = m_pos[i];
                hs_req[i] = 1'b0;
            end
        end else begin
            fwd0  = m_fwd;
            full0 = (m_ids.size() >= DEPTH);
            if (m_fwd && req_tvalid[m_cur] && dn_tready && req_tlast[m_cur]) begin
                m_fwd = 1'b0;
                m_rr  = (m_cur + 1) % N;
            end
            if (m_ids.size() > 0 && rsp_tvalid && out_tready[m_ids[0]] && rsp_tlast) begin
                void'(m_ids.pop_front());
            end
            if (!fwd0 && !full0 && (req_tvalid != '0)) begin
                picked = 1'b0;
                for (int k = 0; k < N; k++) begin
                    j = (m_rr + k) % N;
                    if (!picked && req_tvalid[j]) begin
                        picked = 1'b1;
                        m_cur  = j;
                    end
                end
                m_fwd = 1'b1;
                m_ids.push_back(m_cur);
                do begin
                    e.id   = 8'(m_cur);
                    e.data = beat_data[m_cur][m_pos[m_cur]];
                    e.last = beat_last[m_cur][m_pos[m_cur]];
                    exp_dn.push_back(e);
                    m_pos[m_cur]++;
                end while (!e.last);
            end
        end
    end

    // Stimulus control: packet generation, traffic phases, mid-packet reset
    initial begin
        bit did_mid_reset;
        bit done;
        int nb;
        did_mid_reset = 1'b0;
        done = 1'b0;
        for (int i = 0; i < N; i++) begin
            nbeats[i] = 0;
            rpos[i]   = 0;
            m_pos[i]  = 0;
            hs_req[i] = 1'b0;
            for (int p = 0; p < PKTS; p++) begin
                nb = $urandom_range(1, 5);
                for (int b = 0; b < nb; b++) begin
                    beat_data[i][nbeats[i]] = {8'(i), 24'(p), $urandom};
                    beat_last[i][nbeats[i]] = (b == nb - 1);
                    nbeats[i]++;
                end
            end
        end

        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(posedge clk);
            if (cyc < 150) begin
                p_valid = 100; p_dnr = 100; p_rsp = 100; p_outr = 100;
            end else if (cyc < 500) begin
                p_valid = 70; p_dnr = 80; p_rsp = 8; p_outr = 80;
            end else if (cyc < 900) begin
                p_valid = 80; p_dnr = 70; p_rsp = 90; p_outr = 25;
            end else begin
                p_valid = 85; p_dnr = 85; p_rsp = 85; p_outr = 85;
            end
            if (!did_mid_reset && cyc >= 300 && m_fwd && rpos[m_cur] > 0
                && !beat_last[m_cur][rpos[m_cur] - 1]) begin
                rst_cycles    = 1;
                did_mid_reset = 1'b1;
            end
            done = did_mid_reset && (rst_cycles == 0) && !m_fwd && (m_ids.size() == 0)
                && (exp_dn.size() == 0) && (exp_out.size() == 0) && (ctrl_q.size() == 0);
            for (int i = 0; i < N; i++) begin
                if (rpos[i] != nbeats[i]) done = 1'b0;
            end
            if (done) break;
        end

        repeat (2) @(posedge clk);
        check("run_completed", done, 1'b1);
        check("mid_packet_reset_applied", did_mid_reset, 1'b1);
        check("dn_scoreboard_drained", exp_dn.size(), 0);
        check("out_scoreboard_drained", exp_out.size(), 0);
        check("busy_at_end", busy, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
